stim_sequencer: RTL and testbench
=================================

STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, pattern data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, pattern table entries (power of two, >=2).
REQ-003 SHALL have parameter RST_CYC, default 3, cycles rst_out is held high per run (>=1).
REQ-004 SHALL have parameter HOLD_CYC, default 1, ready cycles each pattern is held (>=1).
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  single-cycle run request.
REQ-008 SHALL have port abort  input  1  terminate the current run.
REQ-009 SHALL have port len  input  $clog2(DEPTH)+1  number of entries to play, sampled on accepted start.
REQ-010 SHALL have ports wr_en / wr_addr / wr_data  input  1 / $clog2(DEPTH) / WIDTH  pattern table write.
REQ-011 SHALL have port pat_ready  input  1  consumer accepts pat_data this cycle.
REQ-012 SHALL have ports pat_data / pat_valid  output  WIDTH / 1  current pattern and qualifier.
REQ-013 SHALL have port rst_out  output  1  generated reset to the stimulated block.
REQ-014 SHALL have ports en_div2 / en_div4  output  1 / 1  clock enables at 1/2 and 1/4 clk rate.
REQ-015 SHALL have ports busy / done  output  1 / 1  run in progress; one-cycle completion pulse.
REQ-016 SHALL have port play_cnt  output  16  entries fully played since last reset.

Function
REQ-017 SHALL implement states IDLE, RST_HOLD, PLAY, DONE.
REQ-018 SHALL move IDLE->RST_HOLD on start; start outside IDLE SHALL be ignored.
REQ-019 SHALL hold rst_out=1 for exactly RST_CYC cycles in RST_HOLD, then enter PLAY with index 0, or DONE if the latched len is 0.
REQ-020 SHALL drive pat_valid=1 and pat_data=table[index] throughout PLAY; pat_data SHALL stay stable while pat_ready=0.
REQ-021 SHALL count pat_ready-high cycles per entry; on the HOLD_CYC-th such cycle the index SHALL advance and play_cnt SHALL increment, saturating at 16'hFFFF.
REQ-022 SHALL go PLAY->DONE after the last entry (index len-1) completes; len > DEPTH SHALL be clamped to DEPTH.
REQ-023 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-024 SHALL return to IDLE on the next cycle when abort=1 in any non-IDLE state, with rst_out=0, pat_valid=0 and no done pulse; abort takes priority over all other transitions.
REQ-025 SHALL accept table writes only in IDLE; writes while busy=1 SHALL be dropped.
REQ-026 SHALL drive busy=1 in RST_HOLD, PLAY and DONE.
REQ-027 SHALL run a free-running 2-bit divider: en_div2=1 when bit0=1, en_div4=1 when value=3; the divider SHALL hold at 0 while rst_out=1.

Reset
REQ-028 SHALL on rst enter IDLE and clear pat_valid, pat_data, rst_out, done, busy, en_div2, en_div4, play_cnt and the divider to 0.
REQ-029 SHALL NOT clear the pattern table on rst.
REQ-030 SHALL let rst mid-run override abort, start and writes in the same cycle.

Configuration
REQ-031 SHALL, with STIM_SEQ_LOOP_EN defined, wrap index len-1 -> 0 and remain in PLAY until abort, never entering DONE from PLAY.
REQ-032 SHALL, without STIM_SEQ_LOOP_EN, behave per REQ-022 and REQ-023.

Structure
REQ-033 SHALL place the state enum type and default WIDTH/DEPTH constants in package stim_seq_pkg.
REQ-034 SHALL implement the divider as sub-module clk_en_div.

Verification
REQ-035 Write table {4,12,3,0}, len=3, pat_ready=1, default parameters -> rst_out high 3 cycles, then pat_data 4,12,3 on consecutive cycles, done pulses, play_cnt=3.
REQ-036 HOLD_CYC=2, pat_ready low for 3 cycles during entry 12 -> 12 remains stable and is held for 2 ready cycles; total PLAY duration 9 cycles.
REQ-037 Abort on the 2nd PLAY cycle -> IDLE next cycle, no done, busy=0, play_cnt=1.
REQ-038 start with len=0 -> 3 rst_out cycles, no pat_valid, done pulse.
REQ-039 wr_en during PLAY to address 0 with value 9 -> next run still plays the original value 4.
REQ-040 STIM_SEQ_LOOP_EN build, len=2, ready=1 -> 4,12,4,12... until abort; done never asserts.

Source files
------------

// File: rtl/stim_seq_pkg.sv
// Shared types and default sizing for the stimulus sequencer.
package stim_seq_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RST_HOLD = 2'd1,
    ST_PLAY     = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/clk_en_div.sv
// Free-running 2-bit divider producing 1/2 and 1/4 rate clock enables.
module clk_en_div (
  input  logic clk,
  input  logic rst,
  input  logic i_hold,
  output logic o_en_div2,
  output logic o_en_div4
);

  logic [1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_hold) begin
      r_cnt <= 2'd0;
    end else begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  assign o_en_div2 = r_cnt[0];
  assign o_en_div4 = (r_cnt == 2'd3);

endmodule

// File: rtl/stim_sequencer.sv
// Stimulus sequencer: generates a reset pulse, then plays a pattern table to a consumer.
// Define STIM_SEQ_LOOP_EN to replay the table continuously until abort.
module stim_sequencer
  import stim_seq_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int RST_CYC  = 3,
  parameter int HOLD_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pat_ready,
  output logic [WIDTH-1:0]         pat_data,
  output logic                     pat_valid,
  output logic                     rst_out,
  output logic                     en_div2,
  output logic                     en_div4,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              play_cnt
);

  localparam int IW  = $clog2(DEPTH);
  localparam int LW  = IW + 1;
  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam int HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  state_t           r_state, w_state_next;
  logic [IW-1:0]    r_idx, w_idx_next;
  logic [HCW-1:0]   r_hold_cnt, w_hold_next;
  logic [RCW-1:0]   r_rst_cnt, w_rst_cnt_next;
  logic [LW-1:0]    r_len, w_len_next;
  logic [LW-1:0]    w_len_clamp;
  logic             w_last;
  logic             w_play_inc;
  logic [15:0]      r_play_cnt;
  logic [WIDTH-1:0] r_pat_data;
  logic [WIDTH-1:0] r_table [DEPTH];

  assign w_len_clamp = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
  assign w_last      = ({1'b0, r_idx} == (r_len - LW'(1)));

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_hold_next    = r_hold_cnt;
    w_rst_cnt_next = r_rst_cnt;
    w_len_next     = r_len;
    w_play_inc     = 1'b0;
    if (r_state != ST_IDLE && abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_next   = ST_RST_HOLD;
            w_rst_cnt_next = '0;
            w_len_next     = w_len_clamp;
            w_idx_next     = '0;
            w_hold_next    = '0;
          end
        end
        ST_RST_HOLD: begin
          if (r_rst_cnt == RCW'(RST_CYC - 1)) begin
            w_state_next = (r_len == '0) ? ST_DONE : ST_PLAY;
            w_idx_next   = '0;
            w_hold_next  = '0;
          end else begin
            w_rst_cnt_next = r_rst_cnt + RCW'(1);
          end
        end
        ST_PLAY: begin
          if (pat_ready) begin
            if (r_hold_cnt == HCW'(HOLD_CYC - 1)) begin
              w_play_inc  = 1'b1;
              w_hold_next = '0;
              if (w_last) begin
`ifdef STIM_SEQ_LOOP_EN
                w_idx_next = '0;
`else
                w_state_next = ST_DONE;
`endif
              end else begin
                w_idx_next = r_idx + IW'(1);
              end
            end else begin
              w_hold_next = r_hold_cnt + HCW'(1);
            end
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_hold_cnt <= '0;
      r_rst_cnt  <= '0;
      r_len      <= '0;
      r_play_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_hold_cnt <= w_hold_next;
      r_rst_cnt  <= w_rst_cnt_next;
      r_len      <= w_len_next;
      if (w_play_inc && r_play_cnt != 16'hFFFF) begin
        r_play_cnt <= r_play_cnt + 16'd1;
      end
    end
  end

  // Table keeps its contents across rst; writes only land while idle.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && r_state == ST_IDLE) begin
      r_table[wr_addr] <= wr_data;
    end
  end

  // Read addressed by the next index so the entry is ready on the first PLAY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat_data <= '0;
    end else if (w_state_next == ST_PLAY) begin
      r_pat_data <= r_table[w_idx_next];
    end
  end

  clk_en_div u_div (
    .clk       (clk),
    .rst       (rst),
    .i_hold    (w_state_next == ST_RST_HOLD),
    .o_en_div2 (en_div2),
    .o_en_div4 (en_div4)
  );

  assign pat_data  = r_pat_data;
  assign pat_valid = (r_state == ST_PLAY);
  assign rst_out   = (r_state == ST_RST_HOLD);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign play_cnt  = r_play_cnt;

endmodule

// File: tb/tb_stim_sequencer.sv
// Self-checking bench for stim_sequencer: vector table, directed corner cases, random vs model.
module tb_stim_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  len = 3'd0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [3:0]  wr_data = 4'd0;
  logic        pat_ready = 1'b0;

  logic [3:0]  pat_data, h2_pat_data;
  logic        pat_valid, h2_pat_valid;
  logic        rst_out, h2_rst_out;
  logic        en_div2, h2_en_div2;
  logic        en_div4, h2_en_div4;
  logic        busy, h2_busy;
  logic        done, h2_done;
  logic [15:0] play_cnt, h2_play_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stim_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pat_ready(pat_ready),
    .pat_data(pat_data), .pat_valid(pat_valid), .rst_out(rst_out),
    .en_div2(en_div2), .en_div4(en_div4), .busy(busy), .done(done), .play_cnt(play_cnt)
  );

  stim_sequencer #(.HOLD_CYC(2)) dut_h2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pat_ready(pat_ready),
    .pat_data(h2_pat_data), .pat_valid(h2_pat_valid), .rst_out(h2_rst_out),
    .en_div2(h2_en_div2), .en_div4(h2_en_div4), .busy(h2_busy), .done(h2_done),
    .play_cnt(h2_play_cnt)
  );

  // Reference model of the default-parameter instance: a run is a reset countdown
  // followed by a queue of table entries, one consumed per ready cycle.
  bit         m_active = 1'b0;
  int         m_rst_left = 0;
  logic [3:0] m_q[$];
  logic [3:0] m_tbl[4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  int         m_play = 0;
  int         m_div = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_update();
    int n;
    if (rst) begin
      m_active = 1'b0;
      m_q.delete();
      m_play = 0;
    end else if (m_active && abort) begin
      m_active = 1'b0;
      m_q.delete();
    end else if (!m_active) begin
      if (wr_en) m_tbl[wr_addr] = wr_data;
      if (start) begin
        m_active   = 1'b1;
        m_rst_left = 3;
        n = (int'(len) > 4) ? 4 : int'(len);
        m_q.delete();
        for (int i = 0; i < n; i++) m_q.push_back(m_tbl[i]);
      end
    end else if (m_rst_left > 0) begin
      m_rst_left--;
    end else if (m_q.size() > 0) begin
      if (pat_ready) begin
`ifdef STIM_SEQ_LOOP_EN
        m_q.push_back(m_q.pop_front());
`else
        void'(m_q.pop_front());
`endif
        if (m_play < 65535) m_play++;
      end
    end else begin
      m_active = 1'b0;
    end
    if (rst || (m_active && m_rst_left > 0)) m_div = 0;
    else m_div = (m_div + 1) % 4;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic check_model();
    bit e_rst, e_valid, e_done;
    e_rst   = m_active && (m_rst_left > 0);
    e_valid = m_active && (m_rst_left == 0) && (m_q.size() > 0);
    e_done  = m_active && (m_rst_left == 0) && (m_q.size() == 0);
    chk("rnd_busy", int'(busy), int'(m_active));
    chk("rnd_rst_out", int'(rst_out), int'(e_rst));
    chk("rnd_pat_valid", int'(pat_valid), int'(e_valid));
    chk("rnd_done", int'(done), int'(e_done));
    if (e_valid) chk("rnd_pat_data", int'(pat_data), int'(m_q[0]));
    chk("rnd_en_div2", int'(en_div2), m_div % 2);
    chk("rnd_en_div4", int'(en_div4), int'(m_div == 3));
    chk("rnd_play_cnt", int'(play_cnt), m_play);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; wr_en = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    bit         start;
    logic [2:0] len;
    bit         ready;
    bit         e_rst_out, e_valid;
    logic [3:0] e_data;
    bit         e_busy, e_done, e_div2, e_div4;
  } vec_t;

  function automatic vec_t mkv(int s, int l, int r, int ro, int pv, int pd,
                               int b, int d, int d2, int d4);
    vec_t v;
    v.start = (s != 0); v.len = 3'(l); v.ready = (r != 0);
    v.e_rst_out = (ro != 0); v.e_valid = (pv != 0); v.e_data = 4'(pd);
    v.e_busy = (b != 0); v.e_done = (d != 0); v.e_div2 = (d2 != 0); v.e_div4 = (d4 != 0);
    return v;
  endfunction

  vec_t vecs[8];
  logic [3:0] init_tbl[4] = '{4'd4, 4'd12, 4'd3, 4'd0};

  initial begin
    vecs[0] = mkv(1, 3, 1, 1, 0, 0, 1, 0, 0, 0);
    vecs[1] = mkv(0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    vecs[2] = mkv(0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    vecs[3] = mkv(0, 0, 1, 0, 1, 4, 1, 0, 1, 0);
    vecs[4] = mkv(0, 0, 1, 0, 1, 12, 1, 0, 0, 0);
    vecs[5] = mkv(0, 0, 1, 0, 1, 3, 1, 0, 1, 1);
    vecs[6] = mkv(0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    vecs[7] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    @(negedge clk);
    do_reset();
    chk("reset_busy", int'(busy), 0);
    chk("reset_rst_out", int'(rst_out), 0);
    chk("reset_pat_valid", int'(pat_valid), 0);
    chk("reset_pat_data", int'(pat_data), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_en_div2", int'(en_div2), 0);
    chk("reset_en_div4", int'(en_div4), 0);
    chk("reset_play_cnt", int'(play_cnt), 0);

    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = init_tbl[i];
      step();
    end
    wr_en = 1'b0;

`ifndef STIM_SEQ_LOOP_EN
    // Basic run: 3 reset cycles, entries 4,12,3, done pulse.
    for (int i = 0; i < 8; i++) begin
      start = vecs[i].start; len = vecs[i].len; pat_ready = vecs[i].ready;
      step();
      start = 1'b0;
      chk($sformatf("vec%0d_rst_out", i), int'(rst_out), int'(vecs[i].e_rst_out));
      chk($sformatf("vec%0d_pat_valid", i), int'(pat_valid), int'(vecs[i].e_valid));
      if (vecs[i].e_valid) chk($sformatf("vec%0d_pat_data", i), int'(pat_data), int'(vecs[i].e_data));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
      chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
      chk($sformatf("vec%0d_en_div2", i), int'(en_div2), int'(vecs[i].e_div2));
      chk($sformatf("vec%0d_en_div4", i), int'(en_div4), int'(vecs[i].e_div4));
    end
    chk("basic_play_cnt", int'(play_cnt), 3);

    // HOLD_CYC=2 instance with a 3-cycle ready stall on entry 12.
    begin
      bit         rdy[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [3:0] dat[9] = '{4'd4, 4'd4, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd3, 4'd3};
      do_reset();
      start = 1'b1; len = 3'd3; pat_ready = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk("h2_rst_out", int'(h2_rst_out), 1);
        step();
      end
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("h2_valid%0d", i), int'(h2_pat_valid), 1);
        chk($sformatf("h2_data%0d", i), int'(h2_pat_data), int'(dat[i]));
        pat_ready = rdy[i];
        step();
      end
      chk("h2_done", int'(h2_done), 1);
      chk("h2_play_cnt", int'(h2_play_cnt), 3);
    end

    // Abort on the second PLAY cycle.
    do_reset();
    start = 1'b1; len = 3'd3; pat_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort_pre_data", int'(pat_data), 12);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_pat_valid", int'(pat_valid), 0);
    chk("abort_rst_out", int'(rst_out), 0);
    chk("abort_play_cnt", int'(play_cnt), 1);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", int'(done), 0);
      step();
    end

    // len=0: reset pulse then straight to done.
    do_reset();
    start = 1'b1; len = 3'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("len0_rst_out", int'(rst_out), 1);
      chk("len0_pat_valid", int'(pat_valid), 0);
      step();
    end
    chk("len0_done", int'(done), 1);
    chk("len0_pat_valid_done", int'(pat_valid), 0);
    step();
    chk("len0_idle", int'(busy), 0);

    // Writes while busy are dropped.
    do_reset();
    start = 1'b1; len = 3'd1; pat_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'd9;
    step();
    wr_en = 1'b0;
    step();
    start = 1'b1; len = 3'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("drop_wr_valid", int'(pat_valid), 1);
    chk("drop_wr_data", int'(pat_data), 4);
`else
    // Loop build: len=2 repeats 4,12 until abort.
    do_reset();
    start = 1'b1; len = 3'd2; pat_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("loop_valid%0d", i), int'(pat_valid), 1);
      chk($sformatf("loop_data%0d", i), int'(pat_data), (i % 2 == 0) ? 4 : 12);
      chk($sformatf("loop_done%0d", i), int'(done), 0);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("loop_abort_busy", int'(busy), 0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      check_model();
      rst       = ($urandom_range(0, 399) == 0);
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 39) == 0);
      len       = 3'($urandom_range(0, 7));
      pat_ready = ($urandom_range(0, 9) < 7);
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_addr   = 2'($urandom_range(0, 3));
      wr_data   = 4'($urandom_range(0, 15));
      step();
    end
    check_model();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
